// File: rtl/axil_external_registers_cu_if.sv
// rtl/axil_external_registers_cu_if.sv - AXI-lite control bus interface
// Carries the AW/W/B/AR/R channels; master drives requests, slave responds.
interface axil_external_registers_cu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_external_registers_cu.sv
// rtl/axil_external_registers_cu.sv - AXI-lite slave bridging to external register streams
// Writes become one write_data beat; reads become a read_address beat plus a read_data wait.
module axil_external_registers_cu #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  axil_external_registers_cu_if.slave axi_in,
  output logic [INDEX_WIDTH-1:0] read_address_tdata,
  output logic                   read_address_tvalid,
  input  logic                   read_address_tready,
  input  logic [DATA_WIDTH-1:0]  read_data_tdata,
  input  logic                   read_data_tvalid,
  output logic                   read_data_tready,
  output logic [DATA_WIDTH-1:0]  write_data_tdata,
  output logic [INDEX_WIDTH-1:0] write_data_tdest,
  output logic                   write_data_tvalid,
  input  logic                   write_data_tready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_EMIT,
    WR_RESP,
    RD_EMIT,
    RD_WAIT,
    RD_RESP
  } state_t;

  function automatic logic [INDEX_WIDTH-1:0] to_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word = addr >> 2;
    return INDEX_WIDTH'(word);
  endfunction

  state_t                 state_q, state_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   arready_q, arready_d;
  logic                   bvalid_q, bvalid_d;
  logic                   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   ra_valid_q, ra_valid_d;
  logic [INDEX_WIDTH-1:0] ra_data_q, ra_data_d;
  logic                   rd_ready_q, rd_ready_d;
  logic                   wd_valid_q, wd_valid_d;
  logic [DATA_WIDTH-1:0]  wd_data_q, wd_data_d;
  logic [INDEX_WIDTH-1:0] wd_dest_q, wd_dest_d;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic unused_wstrb;

  // A read offered together with a write must not handshake: the write wins
  // and the read stays pending until the block is idle again.
  assign axi_in.arready = arready_q & ~axi_in.awvalid & ~axi_in.wvalid;

  assign aw_hs = axi_in.awvalid & awready_q;
  assign w_hs  = axi_in.wvalid & wready_q;
  assign ar_hs = axi_in.arvalid & axi_in.arready;

  assign axi_in.awready = awready_q;
  assign axi_in.wready  = wready_q;
  assign axi_in.bvalid  = bvalid_q;
  assign axi_in.bresp   = 2'b00;
  assign axi_in.rvalid  = rvalid_q;
  assign axi_in.rdata   = rdata_q;
  assign axi_in.rresp   = 2'b00;

  assign read_address_tvalid = ra_valid_q;
  assign read_address_tdata  = ra_data_q;
  assign read_data_tready    = rd_ready_q;
  assign write_data_tvalid   = wd_valid_q;
  assign write_data_tdata    = wd_data_q;
  assign write_data_tdest    = wd_dest_q;

  assign unused_wstrb = ^axi_in.wstrb;

  always_comb begin
    state_d    = state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    arready_d  = arready_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    ra_valid_d = ra_valid_q;
    ra_data_d  = ra_data_q;
    rd_ready_d = rd_ready_q;
    wd_valid_d = wd_valid_q;
    wd_data_d  = wd_data_q;
    wd_dest_d  = wd_dest_q;

    case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        arready_d = 1'b1;
        if (aw_hs || w_hs) begin
          if (aw_hs) wd_dest_d = to_index(axi_in.awaddr);
          if (w_hs)  wd_data_d = axi_in.wdata;
          arready_d = 1'b0;
          if (aw_hs && w_hs) begin
            state_d    = WR_EMIT;
            awready_d  = 1'b0;
            wready_d   = 1'b0;
            wd_valid_d = 1'b1;
          end else begin
            // The ready left high marks the channel still to be collected.
            state_d   = WR_COLLECT;
            awready_d = ~aw_hs;
            wready_d  = ~w_hs;
          end
        end else if (ar_hs) begin
          state_d    = RD_EMIT;
          ra_data_d  = to_index(axi_in.araddr);
          ra_valid_d = 1'b1;
          rd_ready_d = 1'b1;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          arready_d  = 1'b0;
        end
      end

      WR_COLLECT: begin
        if (aw_hs) begin
          wd_dest_d = to_index(axi_in.awaddr);
          awready_d = 1'b0;
        end
        if (w_hs) begin
          wd_data_d = axi_in.wdata;
          wready_d  = 1'b0;
        end
        if ((aw_hs || !awready_q) && (w_hs || !wready_q)) begin
          state_d    = WR_EMIT;
          wd_valid_d = 1'b1;
        end
      end

      WR_EMIT: begin
        if (write_data_tready) begin
          state_d    = WR_RESP;
          wd_valid_d = 1'b0;
          bvalid_d   = 1'b1;
        end
      end

      WR_RESP: begin
        if (axi_in.bready) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          arready_d = 1'b1;
        end
      end

      RD_EMIT: begin
        if (read_address_tready) begin
          ra_valid_d = 1'b0;
          if (read_data_tvalid) begin
            state_d    = RD_RESP;
            rdata_d    = read_data_tdata;
            rvalid_d   = 1'b1;
            rd_ready_d = 1'b0;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (read_data_tvalid) begin
          state_d    = RD_RESP;
          rdata_d    = read_data_tdata;
          rvalid_d   = 1'b1;
          rd_ready_d = 1'b0;
        end
      end

      RD_RESP: begin
        if (axi_in.rready) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          arready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      ra_valid_q <= 1'b0;
      ra_data_q  <= '0;
      rd_ready_q <= 1'b0;
      wd_valid_q <= 1'b0;
      wd_data_q  <= '0;
      wd_dest_q  <= '0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      ra_valid_q <= ra_valid_d;
      ra_data_q  <= ra_data_d;
      rd_ready_q <= rd_ready_d;
      wd_valid_q <= wd_valid_d;
      wd_data_q  <= wd_data_d;
      wd_dest_q  <= wd_dest_d;
    end
  end

endmodule

// File: tb/tb_axil_external_registers_cu.sv
// tb/tb_axil_external_registers_cu.sv - directed and random bench for the register bridge
// A small sink owns the register bank; a shadow array holds the expected contents.
module tb_axil_external_registers_cu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] read_address_tdata;
  logic        read_address_tvalid;
  logic        read_address_tready = 1'b1;
  logic [31:0] read_data_tdata = '0;
  logic        read_data_tvalid = 1'b0;
  logic        read_data_tready;
  logic [31:0] write_data_tdata;
  logic [31:0] write_data_tdest;
  logic        write_data_tvalid;
  logic        write_data_tready = 1'b1;

  axil_external_registers_cu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axil_external_registers_cu #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_WIDTH(32)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .axi_in              (axi),
    .read_address_tdata  (read_address_tdata),
    .read_address_tvalid (read_address_tvalid),
    .read_address_tready (read_address_tready),
    .read_data_tdata     (read_data_tdata),
    .read_data_tvalid    (read_data_tvalid),
    .read_data_tready    (read_data_tready),
    .write_data_tdata    (write_data_tdata),
    .write_data_tdest    (write_data_tdest),
    .write_data_tvalid   (write_data_tvalid),
    .write_data_tready   (write_data_tready)
  );

  always #5 clock = ~clock;

  logic [31:0] sink_regs [4] = '{32'h0, 32'h1234_5678, 32'h0, 32'h0};
  logic        rd_hold = 1'b0;
  int          wr_beats = 0;
  int          rd_beats = 0;
  int          ra_wrcount = 0;
  logic [31:0] last_dest = '0;
  logic [31:0] last_ra = '0;

  // Register sink: one-cycle read latency, optionally withholding the reply.
  always @(posedge clock) begin
    if (write_data_tvalid && write_data_tready) begin
      sink_regs[write_data_tdest[1:0]] <= write_data_tdata;
      last_dest <= write_data_tdest;
      wr_beats  <= wr_beats + 1;
    end
    if (read_data_tvalid && read_data_tready) read_data_tvalid <= 1'b0;
    if (read_address_tvalid && read_address_tready) begin
      last_ra    <= read_address_tdata;
      rd_beats   <= rd_beats + 1;
      ra_wrcount <= wr_beats;
      if (!rd_hold) begin
        read_data_tvalid <= 1'b1;
        read_data_tdata  <= sink_regs[read_address_tdata[1:0]];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    int  n = 0;
    bit  aw_done = 0;
    bit  w_done = 0;
    while (!(aw_done && w_done) && n < 100) begin
      @(negedge clock);
      axi.awaddr  = addr;
      axi.wdata   = data;
      axi.wstrb   = 4'hF;
      axi.awvalid = !aw_done && (n >= aw_dly);
      axi.wvalid  = !w_done && (n >= w_dly);
      #1;
      if (axi.awvalid && axi.awready) aw_done = 1;
      if (axi.wvalid && axi.wready) w_done = 1;
      n++;
    end
    check("wr_addr_data_timeout", 32'(n >= 100), 32'd0);
    @(negedge clock);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b1;
    n = 0;
    while (!axi.bvalid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("wr_resp_timeout", 32'(n >= 100), 32'd0);
    resp = axi.bresp;
    @(negedge clock);
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n = 0;
    bit done = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      axi.araddr  = addr;
      axi.arvalid = 1'b1;
      #1;
      if (axi.arready) done = 1;
      n++;
    end
    check("rd_addr_timeout", 32'(n >= 100), 32'd0);
    @(negedge clock);
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    n = 0;
    while (!axi.rvalid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("rd_resp_timeout", 32'(n >= 100), 32'd0);
    data = axi.rdata;
    resp = axi.rresp;
    @(negedge clock);
    axi.rready = 1'b0;
  endtask

  logic [31:0] shadow [3] = '{32'h0, 32'h1234_5678, 32'h0};
  logic [1:0]  resp, c_wresp, c_rresp;
  logic [31:0] rdata, c_rdata;
  int          wb0, rb0;
  bit          rvalid_seen;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
    axi.bready = 0;  axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;

    repeat (10) @(negedge clock);
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_wready", 32'(axi.wready), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_bvalid", 32'(axi.bvalid), 32'd0);
    check("rst_rvalid", 32'(axi.rvalid), 32'd0);
    check("rst_ra_valid", 32'(read_address_tvalid), 32'd0);
    check("rst_wd_valid", 32'(write_data_tvalid), 32'd0);
    check("rst_rd_ready", 32'(read_data_tready), 32'd0);
    check("rst_wd_dest", write_data_tdest, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_awready", 32'(axi.awready), 32'd1);
    check("idle_wready", 32'(axi.wready), 32'd1);
    check("idle_arready", 32'(axi.arready), 32'd1);

    wb0 = wr_beats;
    axi_write(32'h8, 32'hDEAD_BEEF, 0, 0, resp);
    shadow[2] = 32'hDEAD_BEEF;
    check("wr_bresp", 32'(resp), 32'd0);
    check("wr_beats", 32'(wr_beats - wb0), 32'd1);
    check("wr_dest", last_dest, 32'd2);
    check("wr_sink", sink_regs[2], 32'hDEAD_BEEF);
    repeat (4) @(negedge clock);
    check("wr_no_extra", 32'(wr_beats - wb0), 32'd1);

    axi_read(32'h4, rdata, resp);
    check("rd_index", last_ra, 32'd1);
    check("rd_data", rdata, 32'h1234_5678);
    check("rd_rresp", 32'(resp), 32'd0);

    // W leads AW by three cycles while the sink stalls the beat.
    write_data_tready = 1'b0;
    wb0 = wr_beats;
    fork
      axi_write(32'h4, 32'hA5A5_0F0F, 3, 0, resp);
      begin : stall
        int n;
        n = 0;
        while (!write_data_tvalid && n < 100) begin
          @(negedge clock);
          n++;
        end
        check("bp_valid_timeout", 32'(n >= 100), 32'd0);
        repeat (5) begin
          check("bp_valid", 32'(write_data_tvalid), 32'd1);
          check("bp_data", write_data_tdata, 32'hA5A5_0F0F);
          check("bp_dest", write_data_tdest, 32'd1);
          check("bp_no_bvalid", 32'(axi.bvalid), 32'd0);
          @(negedge clock);
        end
        write_data_tready = 1'b1;
      end
    join
    shadow[1] = 32'hA5A5_0F0F;
    check("bp_bresp", 32'(resp), 32'd0);
    check("bp_beats", 32'(wr_beats - wb0), 32'd1);
    check("bp_sink", sink_regs[1], 32'hA5A5_0F0F);

    wb0 = wr_beats;
    fork
      axi_write(32'h0, 32'h0BAD_F00D, 0, 0, c_wresp);
      axi_read(32'h8, c_rdata, c_rresp);
    join
    shadow[0] = 32'h0BAD_F00D;
    check("cont_write_first", 32'(ra_wrcount), 32'(wb0 + 1));
    check("cont_bresp", 32'(c_wresp), 32'd0);
    check("cont_rdata", c_rdata, 32'hDEAD_BEEF);
    check("cont_sink", sink_regs[0], 32'h0BAD_F00D);

    for (int i = 0; i < 200; i++) begin
      int unsigned idx;
      logic [31:0] addr, data;
      idx  = $urandom_range(0, 2);
      addr = 32'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        axi_write(addr, data, $urandom_range(0, 2), $urandom_range(0, 2), resp);
        shadow[idx] = data;
        check("mix_bresp", 32'(resp), 32'd0);
        for (int j = 0; j < 3; j++) check("mix_bank", sink_regs[j], shadow[j]);
      end else begin
        axi_read(addr, rdata, resp);
        check("mix_rdata", rdata, shadow[idx]);
      end
    end

    // Abort a read while it waits for the sink's reply.
    rd_hold = 1'b1;
    rb0 = rd_beats;
    @(negedge clock);
    axi.araddr  = 32'h4;
    axi.arvalid = 1'b1;
    @(negedge clock);
    axi.arvalid = 1'b0;
    repeat (2) @(negedge clock);
    check("abort_addr_beat", 32'(rd_beats - rb0), 32'd1);
    check("abort_rd_ready", 32'(read_data_tready), 32'd1);
    axi.rready  = 1'b1;
    reset       = 1'b0;
    rvalid_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) reset = 1'b1;
      @(negedge clock);
      rvalid_seen = rvalid_seen | axi.rvalid;
    end
    check("abort_no_rvalid", 32'(rvalid_seen), 32'd0);
    axi.rready = 1'b0;
    rd_hold    = 1'b0;
    axi_read(32'h4, rdata, resp);
    check("post_abort_rdata", rdata, shadow[1]);
    check("post_abort_rresp", 32'(resp), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_external_registers_cu.md
Name: axil_external_registers_cu

Overview:
- AXI-lite slave control unit that maps a bank of registers held outside the block onto AXI-stream side channels.
- Bus writes become write_data stream beats carrying register index plus data.
- Bus reads become a read_address stream beat carrying the register index, followed by a wait for the returned read_data beat, which is then presented as RDATA.
- Sits between the processor interconnect and user peripheral logic that owns the register storage.

Parameters:
- ADDR_WIDTH, 32, AXI-lite address width.
- DATA_WIDTH, 32, AXI-lite and stream data width.
- INDEX_WIDTH, 32, width of register index on read_address.data and write_data.dest.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- axi_in  axi_lite slave  ADDR_WIDTH/DATA_WIDTH  control bus: AW/W/B/AR/R channels.
- read_address  axi_stream master  INDEX_WIDTH  register index to read (data, valid; ready from sink).
- read_data  axi_stream slave  DATA_WIDTH  returned register value (data, valid); ready driven by this block.
- write_data  axi_stream master  DATA_WIDTH  data = WDATA, dest = register index, valid; ready from sink.

Behaviour:
- Register index = AXI address >> 2 (byte address to word index); low 2 bits ignored; WSTRB ignored (full-word writes).
- Reset (reset==0 at clock edge):
  - AWREADY, WREADY, BVALID, ARREADY, RVALID, read_address.valid, write_data.valid, read_data.ready all 0; data/dest outputs 0; FSM to IDLE.
  - Any in-flight transaction is abandoned with no stream beat and no response.
- FSM states: IDLE, WR_COLLECT, WR_EMIT, WR_RESP, RD_EMIT, RD_WAIT, RD_RESP.
- IDLE:
  - AWREADY=WREADY=ARREADY=1.
  - If AWVALID or WVALID, capture whichever handshakes and go to WR_COLLECT; if both handshake in the same cycle, go directly to WR_EMIT.
  - Else if ARVALID, capture ARADDR and go to RD_EMIT.
  - Simultaneous AW and AR in IDLE: write wins; AR stays pending (ARREADY deasserted once write is chosen).
- WR_COLLECT: keep READY high only on the channel not yet captured; when it handshakes, go to WR_EMIT. AW and W may arrive in either order.
- WR_EMIT:
  - write_data.valid=1, dest=index, data=captured WDATA.
  - Hold until write_data.ready=1, then valid drops next cycle and go to WR_RESP.
  - Exactly one beat per bus write.
- WR_RESP: BVALID=1, BRESP=OKAY(00); on BREADY go to IDLE. The stream beat always precedes BVALID.
- RD_EMIT:
  - read_address.valid=1, data=index; hold until read_address.ready.
  - read_data.ready=1 from the read_address handshake cycle onward.
  - Go to RD_WAIT (or RD_RESP directly if read_data.valid is already 1).
- RD_WAIT:
  - read_data.ready=1; wait with no timeout for read_data.valid.
  - Capture read_data.data; go to RD_RESP.
  - Returned data arrives at least 1 cycle after the address beat (sink latency 1 is the nominal case).
- RD_RESP: RVALID=1, RDATA=captured value, RRESP=OKAY; on RREADY go to IDLE. read_data.ready=0 outside RD_EMIT/RD_WAIT.
- Only one outstanding transaction at a time; no pipelining.
- Back-to-back transactions: IDLE is re-entered one cycle after B/R completes.
- Latency with always-ready sinks:
  - Write: stream beat 1 cycle after AW+W capture; BVALID 1 cycle after the beat.
  - Read: address beat 1 cycle after AR capture; RVALID 1 cycle after read_data.valid.

Test Plan:
- Reset: hold reset=0 for 10 cycles -> every valid/ready output 0; release -> AWREADY/WREADY/ARREADY=1 in IDLE.
- Write: write 0xDEADBEEF to byte address 0x8 -> one write_data beat with dest=2, data=0xDEADBEEF, then BRESP=00; no extra beats.
- Read: sink holds reg1=0x12345678 and returns it 1 cycle after the address beat; bus read of 0x4 -> read_address.data=1, RDATA=0x12345678, RRESP=00.
- Random mix: 200 random writes and reads to indices 0..2 with random data -> shadow model equals sink register bank after each write; every read returns the sink's value.
- Ordering and backpressure: W before AW by 3 cycles, and write_data.ready low for 5 cycles -> beat held stable; BVALID only after the handshake; correct dest and data.
- Contention and reset abort: AW+W and AR in the same cycle -> write completes first, then read. Separately, assert reset during RD_WAIT -> no RVALID; after release, a new read completes normally.
